savestate_sequencer: RTL and testbench

Initiator side of the 64-bit save-state request bus. On an `ss_save` or `ss_load` rising edge it walks the core's state space, one 64-bit word at a time. Save moves core words into save-state RAM, prefixed by a header word. Load validates the header, then writes each stored word back into the core. It sits between the NES core's state-register mux and `save_state_controller`, and runs entirely on the PPU clock.

---
 rtl/savestate_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_savestate_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/savestate_sequencer.sv
// Save-state initiator: streams core state words to/from the save-state RAM over the
// 64-bit request bus, with a header word at address 0 that is validated on load.
module savestate_sequencer #(
  parameter int          STATE_WORDS     = 1024,
  parameter int          CORE_ADDR_W     = 16,
  parameter int          CORE_RD_LATENCY = 2,
  parameter int          START_DELAY     = 8,
  parameter logic [31:0] MAGIC           = 32'h5353_4E45,
  parameter logic [15:0] VERSION         = 16'h0001
) (
  input  logic                   clk_ppu_21_47,
  input  logic                   reset,
  input  logic                   ss_save,
  input  logic                   ss_load,
  output logic [25:0]            ss_addr,
  output logic [63:0]            ss_din,
  input  logic [63:0]            ss_dout,
  output logic                   ss_rnw,
  output logic                   ss_req,
  output logic [7:0]             ss_be,
  input  logic                   ss_ack,
  output logic                   ss_busy,
  output logic                   core_pause,
  output logic [CORE_ADDR_W-1:0] core_addr,
  output logic                   core_rd,
  input  logic [63:0]            core_rdata,
  output logic                   core_wr,
  output logic [63:0]            core_wdata,
  output logic                   ss_done,
  output logic                   ss_err
);

  typedef enum logic [3:0] {
    IDLE, START_WAIT, SAVE_HDR, SAVE_FETCH, SAVE_REQ, SAVE_ACK, LOAD_REQ, LOAD_ACK, FINISH
  } state_t;

  localparam logic [15:0] LAST_IDX   = 16'(STATE_WORDS);
  localparam logic [63:0] HEADER     = {MAGIC, VERSION, LAST_IDX};
  localparam logic [31:0] DELAY_LAST = 32'(START_DELAY - 1);
  localparam logic [31:0] RD_LAST    = 32'(CORE_RD_LATENCY);

  state_t                 state, state_n;
  logic                   save_q, load_q, save_edge, load_edge;
  logic                   is_load, is_load_n;
  logic [15:0]            word_idx, word_idx_n;
  logic [31:0]            cnt, cnt_n;
  logic [25:0]            ss_addr_n;
  logic [63:0]            ss_din_n, core_wdata_n;
  logic [CORE_ADDR_W-1:0] core_addr_n;
  logic                   ss_rnw_n, ss_req_n, busy_n, pause_n, core_rd_n, core_wr_n, done_n, err_n;

  assign save_edge = ss_save & ~save_q;
  assign load_edge = ss_load & ~load_q;
  assign ss_be     = 8'hFF;

  always_comb begin
    state_n      = state;
    is_load_n    = is_load;
    word_idx_n   = word_idx;
    cnt_n        = cnt;
    ss_addr_n    = ss_addr;
    ss_din_n     = ss_din;
    ss_rnw_n     = ss_rnw;
    busy_n       = ss_busy;
    pause_n      = core_pause;
    core_addr_n  = core_addr;
    core_wdata_n = core_wdata;
    err_n        = ss_err;
    ss_req_n     = 1'b0;
    core_rd_n    = 1'b0;
    core_wr_n    = 1'b0;
    done_n       = 1'b0;

    case (state)
      IDLE: begin
        if (load_edge || save_edge) begin
          state_n    = START_WAIT;
          is_load_n  = load_edge;
          busy_n     = 1'b1;
          pause_n    = 1'b1;
          err_n      = 1'b0;
          word_idx_n = 16'd0;
          cnt_n      = 32'd0;
        end
      end
      START_WAIT: begin
        if (cnt == DELAY_LAST) state_n = is_load ? LOAD_REQ : SAVE_HDR;
        else                   cnt_n   = cnt + 32'd1;
      end
      SAVE_HDR: begin
        ss_din_n = HEADER;
        state_n  = SAVE_REQ;
      end
      // cnt == 0 is the core_rd cycle, so the read data is valid when cnt reaches the latency
      SAVE_FETCH: begin
        if (cnt == RD_LAST) begin
          ss_din_n = core_rdata;
          state_n  = SAVE_REQ;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      SAVE_REQ: state_n = SAVE_ACK;
      SAVE_ACK: begin
        if (ss_ack) begin
          if (word_idx == LAST_IDX) begin
            state_n = FINISH;
          end else begin
            word_idx_n  = word_idx + 16'd1;
            core_addr_n = CORE_ADDR_W'(word_idx);
            core_rd_n   = 1'b1;
            cnt_n       = 32'd0;
            state_n     = SAVE_FETCH;
          end
        end
      end
      LOAD_REQ: state_n = LOAD_ACK;
      LOAD_ACK: begin
        if (ss_ack) begin
          if (word_idx == 16'd0) begin
            if (ss_dout != HEADER) begin
              err_n   = 1'b1;
              state_n = FINISH;
            end else begin
              word_idx_n = word_idx + 16'd1;
              state_n    = LOAD_REQ;
            end
          end else begin
            core_wr_n    = 1'b1;
            core_addr_n  = CORE_ADDR_W'(word_idx - 16'd1);
            core_wdata_n = ss_dout;
            if (word_idx == LAST_IDX) begin
              state_n = FINISH;
            end else begin
              word_idx_n = word_idx + 16'd1;
              state_n    = LOAD_REQ;
            end
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Request-phase and end-of-sequence outputs are keyed off the state being entered
    if (state_n == SAVE_REQ || state_n == LOAD_REQ) begin
      ss_req_n  = 1'b1;
      ss_addr_n = 26'({word_idx_n, 1'b0});
      ss_rnw_n  = (state_n == LOAD_REQ);
    end
    if (state_n == FINISH) begin
      busy_n  = 1'b0;
      pause_n = 1'b0;
      done_n  = 1'b1;
    end
  end

  always_ff @(posedge clk_ppu_21_47) begin
    if (reset) begin
      state      <= IDLE;
      save_q     <= 1'b0;
      load_q     <= 1'b0;
      is_load    <= 1'b0;
      word_idx   <= 16'd0;
      cnt        <= 32'd0;
      ss_addr    <= 26'd0;
      ss_din     <= 64'd0;
      ss_rnw     <= 1'b0;
      ss_req     <= 1'b0;
      ss_busy    <= 1'b0;
      core_pause <= 1'b0;
      core_addr  <= '0;
      core_rd    <= 1'b0;
      core_wr    <= 1'b0;
      core_wdata <= 64'd0;
      ss_done    <= 1'b0;
      ss_err     <= 1'b0;
    end else begin
      state      <= state_n;
      save_q     <= ss_save;
      load_q     <= ss_load;
      is_load    <= is_load_n;
      word_idx   <= word_idx_n;
      cnt        <= cnt_n;
      ss_addr    <= ss_addr_n;
      ss_din     <= ss_din_n;
      ss_rnw     <= ss_rnw_n;
      ss_req     <= ss_req_n;
      ss_busy    <= busy_n;
      core_pause <= pause_n;
      core_addr  <= core_addr_n;
      core_rd    <= core_rd_n;
      core_wr    <= core_wr_n;
      core_wdata <= core_wdata_n;
      ss_done    <= done_n;
      ss_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_savestate_sequencer.sv
// Bench for savestate_sequencer: a RAM/controller model and a core-state model respond to
// the DUT, and every request, write-back and end-of-sequence event is checked against them.
module tb_savestate_sequencer;

  localparam int          SW  = 4;
  localparam int          LAT = 2;
  localparam int          SD  = 8;
  localparam int          CAW = 16;
  localparam logic [63:0] HDR = {32'h5353_4E45, 16'h0001, 16'd4};

  logic            clk;
  logic            reset, ss_save, ss_load;
  logic [25:0]     ss_addr;
  logic [63:0]     ss_din, ss_dout;
  logic            ss_rnw, ss_req, ss_ack;
  logic [7:0]      ss_be;
  logic            ss_busy, core_pause;
  logic [CAW-1:0]  core_addr;
  logic            core_rd, core_wr;
  logic [63:0]     core_rdata, core_wdata;
  logic            ss_done, ss_err;

  savestate_sequencer #(
    .STATE_WORDS(SW), .CORE_ADDR_W(CAW), .CORE_RD_LATENCY(LAT), .START_DELAY(SD)
  ) dut (
    .clk_ppu_21_47(clk), .reset(reset), .ss_save(ss_save), .ss_load(ss_load),
    .ss_addr(ss_addr), .ss_din(ss_din), .ss_dout(ss_dout), .ss_rnw(ss_rnw),
    .ss_req(ss_req), .ss_be(ss_be), .ss_ack(ss_ack), .ss_busy(ss_busy),
    .core_pause(core_pause), .core_addr(core_addr), .core_rd(core_rd),
    .core_rdata(core_rdata), .core_wr(core_wr), .core_wdata(core_wdata),
    .ss_done(ss_done), .ss_err(ss_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem  [0:SW];
  logic [63:0] core [0:SW-1];

  int total = 0, bad = 0;
  int req_cnt = 0, ack_cnt = 0, cw_cnt = 0, done_cnt = 0;
  int dup_cnt = 0, wide_cnt = 0, hold_cnt = 0;
  int ack_lo = 3, ack_hi = 3;
  logic exp_rnw = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Controller RAM and core-state responder, acting half-way into each cycle
  initial begin : responder
    int idx, ack_at, rd_due, rd_a, last_ack, seq_req, start_c;
    logic [25:0] p_addr;
    logic [63:0] p_din;
    logic p_rnw;
    bit pending, chk_end, chk_cw, prev_req, prev_busy, first;
    ss_ack = 1'b0; ss_dout = '0; core_rdata = '0;
    pending = 0; chk_end = 0; chk_cw = 0; prev_req = 0; prev_busy = 0; first = 0;
    rd_due = -1; rd_a = 0; last_ack = 0; seq_req = 0; start_c = 0; ack_at = 0;
    p_addr = '0; p_din = '0; p_rnw = 1'b0;
    forever begin
      @(posedge clk); #2;
      ss_ack = 1'b0;
      core_rdata = {$urandom, $urandom};
      if (chk_end) begin
        checkOutput("busy_fall", ss_busy, 0);
        checkOutput("done_pulse", ss_done, 1);
      end
      if (chk_cw) checkOutput("core_wr_timing", core_wr, 1);
      chk_end = 0; chk_cw = 0;
      if (ss_busy && !prev_busy) begin
        seq_req = 0; start_c = cyc - 1; first = 1;
      end
      prev_busy = ss_busy;
      if (!ss_busy) pending = 0;
      if (ss_done) done_cnt++;
      if (core_wr) begin
        cw_cnt++;
        if (int'(core_addr) < SW) core[int'(core_addr)] = core_wdata;
      end
      if (rd_due == cyc && rd_a < SW) core_rdata = core[rd_a];
      if (core_rd) begin
        rd_due = cyc + LAT; rd_a = int'(core_addr);
      end
      if (ss_req && prev_req) wide_cnt++;
      prev_req = ss_req;
      if (ss_req) begin
        if (pending) dup_cnt++;
        req_cnt++;
        checkOutput("req_addr", ss_addr, 64'(2 * seq_req));
        checkOutput("req_rnw", ss_rnw, exp_rnw);
        if (first)
          checkOutput("first_req_delay", (cyc - start_c >= SD + 1) && (cyc - start_c <= SD + 2), 1);
        else
          checkOutput("req_gap", cyc - last_ack, ss_rnw ? 1 : LAT + 2);
        if (!ss_rnw && seq_req <= SW)
          checkOutput("req_din", ss_din, (seq_req == 0) ? HDR : core[seq_req - 1]);
        first = 0; seq_req++;
        pending = 1; p_addr = ss_addr; p_din = ss_din; p_rnw = ss_rnw;
        ack_at = cyc + $urandom_range(ack_hi, ack_lo);
      end else if (pending && (ss_addr !== p_addr || ss_din !== p_din || ss_rnw !== p_rnw)) begin
        hold_cnt++;
      end
      if (pending && cyc == ack_at) begin
        ss_ack = 1'b1; idx = int'(p_addr >> 1); pending = 0; last_ack = cyc; ack_cnt++;
        if (idx <= SW) begin
          if (p_rnw) begin
            ss_dout = mem[idx];
            chk_cw  = (idx != 0);
            chk_end = (idx == SW) || (idx == 0 && mem[0] != HDR);
          end else begin
            mem[idx] = p_din;
            chk_end  = (idx == SW);
          end
        end
      end else begin
        ss_dout = {$urandom, $urandom};
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic sv, input logic ld);
    tick(1);
    ss_save = sv; ss_load = ld;
    tick(1);
    ss_save = 1'b0; ss_load = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin tick(1); n++; end
    checkOutput(tag, done_cnt != d0, 1);
    tick(4);
    checkOutput({tag, "_once"}, done_cnt - d0, 1);
  endtask

  task automatic runSave(input string tag);
    int r0 = req_cnt, d0 = done_cnt, h0 = hold_cnt, p0 = dup_cnt, w0 = wide_cnt;
    for (int i = 0; i <= SW; i++) mem[i] = '0;
    exp_rnw = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput({tag, "_start"}, {ss_busy, core_pause, ss_err}, 3'b110);
    waitDone(tag, d0);
    checkOutput({tag, "_reqs"}, req_cnt - r0, SW + 1);
    checkOutput({tag, "_hdr"}, mem[0], HDR);
    for (int k = 0; k < SW; k++) checkOutput({tag, "_word"}, mem[k + 1], core[k]);
    checkOutput({tag, "_protocol"}, (hold_cnt - h0) + (dup_cnt - p0) + (wide_cnt - w0), 0);
    checkOutput({tag, "_idle"}, {ss_busy, core_pause}, 0);
  endtask

  task automatic runLoad(input string tag, input logic [63:0] hdr, input logic both, input int poke);
    int r0 = req_cnt, d0 = done_cnt, c0 = cw_cnt, h0 = hold_cnt, p0 = dup_cnt, w0 = wide_cnt;
    logic [63:0] exp_core [0:SW-1];
    bit hdr_bad;
    hdr_bad = (hdr != HDR);
    mem[0] = hdr;
    for (int k = 0; k < SW; k++) begin
      mem[k + 1]  = {$urandom, $urandom};
      core[k]     = {$urandom, $urandom};
      exp_core[k] = hdr_bad ? core[k] : mem[k + 1];
    end
    exp_rnw = 1'b1;
    applyStimulus(both, 1'b1);
    if (poke > 0) begin
      tick(poke); ss_save = 1'b1; tick(1); ss_save = 1'b0;
    end
    waitDone(tag, d0);
    checkOutput({tag, "_reqs"}, req_cnt - r0, hdr_bad ? 1 : SW + 1);
    checkOutput({tag, "_core_wrs"}, cw_cnt - c0, hdr_bad ? 0 : SW);
    for (int k = 0; k < SW; k++) checkOutput({tag, "_core"}, core[k], exp_core[k]);
    checkOutput({tag, "_err"}, ss_err, hdr_bad);
    checkOutput({tag, "_protocol"}, (hold_cnt - h0) + (dup_cnt - p0) + (wide_cnt - w0), 0);
    if (poke > 0) begin
      tick(30);
      checkOutput({tag, "_no_restart"}, {req_cnt - r0, 1'b0, ss_busy}, {SW + 1, 1'b0, 1'b0});
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int a0, d0, n;
    reset = 1'b1; ss_save = 1'b0; ss_load = 1'b0;
    tick(3);
    checkOutput("reset_be", ss_be, 8'hFF);
    checkOutput("reset_ctrl", {ss_rnw, ss_req, ss_busy, core_pause, core_rd, core_wr, ss_done, ss_err}, 0);
    checkOutput("reset_addr", {ss_addr, core_addr}, 0);
    checkOutput("reset_din", ss_din, 0);
    checkOutput("reset_wdata", core_wdata, 0);
    reset = 1'b0;
    tick(2);

    $display("[TB] save with fixed core pattern, ack after 3 cycles");
    for (int k = 0; k < SW; k++) core[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
    ack_lo = 3; ack_hi = 3;
    runSave("save_plan");

    $display("[TB] load with valid header");
    runLoad("load_ok", HDR, 1'b0, 0);

    $display("[TB] load with bad magic");
    runLoad("load_badmagic", {32'hDEAD_BEEF, 16'h0001, 16'd4}, 1'b0, 0);
    tick(5);
    checkOutput("err_held", ss_err, 1);

    $display("[TB] save with 40-cycle ack, error clears on start");
    ack_lo = 40; ack_hi = 40;
    runSave("save_slow");

    $display("[TB] reset after second ack of a save");
    ack_lo = 3; ack_hi = 3;
    a0 = ack_cnt; d0 = done_cnt; n = 0;
    exp_rnw = 1'b0;
    applyStimulus(1'b1, 1'b0);
    while (ack_cnt - a0 < 2 && n < 500) begin tick(1); n++; end
    checkOutput("rst_second_ack", ack_cnt - a0 >= 2, 1);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_abort", {ss_busy, core_pause, ss_req, core_rd, ss_done}, 0);
    reset = 1'b0;
    tick(20);
    checkOutput("rst_no_done", done_cnt - d0, 0);
    for (int k = 0; k < SW; k++) core[k] = {$urandom, $urandom};
    runSave("save_restart");

    $display("[TB] simultaneous edges, save edge during load");
    runLoad("load_both", HDR, 1'b1, 12);

    $display("[TB] randomized sequences");
    for (int r = 0; r < 6; r++) begin
      ack_lo = 1; ack_hi = $urandom_range(8, 1);
      if ($urandom_range(1, 0) == 1) begin
        for (int k = 0; k < SW; k++) core[k] = {$urandom, $urandom};
        runSave("rand_save");
      end else if ($urandom_range(2, 0) == 0) begin
        runLoad("rand_load_bad", HDR ^ (64'd1 << $urandom_range(63, 0)), 1'($urandom_range(1, 0)), 0);
      end else begin
        runLoad("rand_load", HDR, 1'($urandom_range(1, 0)), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
